hex_page_scheduler: RTL and testbench
=====================================

HEX_PAGE_SCHEDULER -- requirements
Module: hex_page_scheduler

Interface
REQ-001 SHALL have parameter TICKS_PER_PAGE, default 50000000, clock cycles each stat page is shown.
REQ-002 SHALL have parameter ALERT_TICKS, default 100000000, clock cycles an alert is shown.
REQ-003 SHALL have parameter BLINK_TICKS, default 12500000, alert blink half-period in cycles.
REQ-004 SHALL have port clock  in  1  rising-edge system clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port stat_valid  in  3  per-source present flag, bit i for stat i.
REQ-007 SHALL have ports stat0, stat1, stat2  in  16 each  four-nibble source values.
REQ-008 SHALL have port alert_req  in  1  priority display request, level.
REQ-009 SHALL have port alert_val  in  16  alert value, sampled on acceptance.
REQ-010 SHALL have port hold  in  1  freezes stat page rotation.
REQ-011 SHALL have port alert_ack  out  1  one-cycle pulse on alert acceptance.
REQ-012 SHALL have port nib  out  16  nibbles for the four hex decoders, [15:12] leftmost.
REQ-013 SHALL have port blank  out  4  per-digit blank, bit 3 leftmost, 1 = dark.
REQ-014 SHALL have port page  out  2  shown source: 0-2 stat index, 3 alert.

Function
REQ-015 SHALL implement states IDLE, SHOW, ALERT; all outputs registered, updating one cycle after the causing input.
REQ-016 IDLE: SHALL drive blank=4'hF, nib=0; alert_req=1 -> ALERT; else any stat_valid -> SHOW, page = lowest valid index.
REQ-017 SHOW: nib SHALL track stat[page] live, registered, each cycle.
REQ-018 SHOW: page counter SHALL increment per cycle while hold=0, hold at its value while hold=1.
REQ-019 At count TICKS_PER_PAGE-1, counter SHALL clear and page advance to the next valid index after current, round-robin 2->0; a single valid source stays put.
REQ-020 If stat_valid[page] drops in SHOW, SHALL advance on the next cycle regardless of hold, counter cleared; no valid source -> IDLE.
REQ-021 SHOW leading-zero blanking: blank[3] = nib[15:12]==0; blank[k] = blank[k+1] and nibble k==0 for k=2,1; blank[0]=0.
REQ-022 alert_req=1 in IDLE or SHOW SHALL be accepted: latch alert_val, pulse alert_ack one cycle, save current page, enter ALERT, page=3.
REQ-023 Alert acceptance coinciding with a page wrap SHALL win; the saved page is the pre-wrap page.
REQ-024 ALERT: nib = latched value; no leading-zero blanking; blank alternates 4'h0 / 4'hF every BLINK_TICKS cycles, starting 4'h0.
REQ-025 ALERT SHALL ignore alert_req (no ack) and hold, lasting exactly ALERT_TICKS cycles.
REQ-026 ALERT exit: saved page if still valid, else next valid after it, else IDLE; page counter cleared.
REQ-027 alert_req held high across ALERT exit SHALL be re-accepted on the first cycle after exit.
REQ-028 Counters SHALL be sized to hold their parameter minus one without overflow.

Reset
REQ-029 reset=1 SHALL force IDLE, page=0, nib=0, blank=4'hF, alert_ack=0, all counters and saved page 0, overriding all other inputs, mid-alert included.
REQ-030 First cycle after reset deassertion SHALL evaluate REQ-016 normally.

Verification (TICKS_PER_PAGE=4, ALERT_TICKS=8, BLINK_TICKS=2)
REQ-031 stat_valid=3'b101, stat0=16'h0042, stat2=16'h1234 -> page 0 with blank=4'b1100, nib=0042 for 4 cycles, then page 2 with blank=0, then page 0.
REQ-032 hold=1 for 10 cycles in SHOW -> page unchanged; after hold=0, wrap after the remaining count.
REQ-033 alert_req pulse, alert_val=16'hBEEF, in page 2 -> alert_ack one cycle, page=3, blank 0,0,F,F,0,0,F,F over 8 cycles, then page 2.
REQ-034 stat_valid[page] cleared mid-page -> next valid page the following cycle; all cleared -> IDLE, blank=4'hF.
REQ-035 reset asserted during ALERT -> next cycle blank=4'hF, page=0, alert_ack=0; alert_req still high after release -> accepted with a fresh ack.

Source files
------------

// File: rtl/hex_page_scheduler.sv
// Hex display page scheduler: rotates through up to three 16-bit stat sources
// on a four-digit hex display, with a blinking priority alert page that
// temporarily takes over the display and then returns to the interrupted page.
module hex_page_scheduler #(
  parameter int TICKS_PER_PAGE = 50000000,
  parameter int ALERT_TICKS    = 100000000,
  parameter int BLINK_TICKS    = 12500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  stat_valid,
  input  logic [15:0] stat0,
  input  logic [15:0] stat1,
  input  logic [15:0] stat2,
  input  logic        alert_req,
  input  logic [15:0] alert_val,
  input  logic        hold,
  output logic        alert_ack,
  output logic [15:0] nib,
  output logic [3:0]  blank,
  output logic [1:0]  page
);

  localparam int PW = (TICKS_PER_PAGE > 1) ? $clog2(TICKS_PER_PAGE) : 1;
  localparam int AW = (ALERT_TICKS > 1) ? $clog2(ALERT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PAGE_LAST  = PW'(TICKS_PER_PAGE - 1);
  localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

  state_t        state, state_n;
  logic [PW-1:0] cnt, cnt_n;
  logic [AW-1:0] acnt, acnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [1:0]    saved, saved_n;
  logic [1:0]    page_n;
  logic [15:0]   nib_n;
  logic [3:0]    blank_n;
  logic          ack_n;
  logic          accept;
  logic [2:0]    hit;

  // First valid source scanning base, base+1, base+2 (mod 3); returns {found, index}
  function automatic logic [2:0] find_valid(input logic [1:0] base, input logic [2:0] valid);
    logic [2:0] s;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      s = {1'b0, base} + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (s >= 3'd3) s = s - 3'd3;
      if (valid[s[1:0]]) res = {1'b1, s[1:0]};
    end
    return res;
  endfunction

  function automatic logic [15:0] pick_stat(input logic [1:0] idx);
    case (idx)
      2'd0:    return stat0;
      2'd1:    return stat1;
      default: return stat2;
    endcase
  endfunction

  // Leading-zero blanking; the rightmost digit is never blanked so zero shows as "0"
  function automatic logic [3:0] lz_blank(input logic [15:0] n);
    logic [3:0] b;
    b[3] = (n[15:12] == 4'h0);
    b[2] = b[3] & (n[11:8] == 4'h0);
    b[1] = b[2] & (n[7:4] == 4'h0);
    b[0] = 1'b0;
    return b;
  endfunction

  // State and output registers; reset forces the dark idle display
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      page      <= 2'd0;
      nib       <= 16'h0000;
      blank     <= 4'hF;
      alert_ack <= 1'b0;
      cnt       <= '0;
      acnt      <= '0;
      bcnt      <= '0;
      saved     <= 2'd0;
    end else begin
      state     <= state_n;
      page      <= page_n;
      nib       <= nib_n;
      blank     <= blank_n;
      alert_ack <= ack_n;
      cnt       <= cnt_n;
      acnt      <= acnt_n;
      bcnt      <= bcnt_n;
      saved     <= saved_n;
    end
  end

  // Next state and next registered outputs; alert acceptance outranks page rotation
  always_comb begin
    state_n = state;
    page_n  = page;
    nib_n   = nib;
    blank_n = blank;
    ack_n   = 1'b0;
    cnt_n   = cnt;
    acnt_n  = acnt;
    bcnt_n  = bcnt;
    saved_n = saved;
    hit     = 3'b000;
    accept  = alert_req && (state != ALERT);

    if (accept) begin
      state_n = ALERT;
      saved_n = page;
      page_n  = 2'd3;
      nib_n   = alert_val;
      blank_n = 4'h0;
      ack_n   = 1'b1;
      cnt_n   = '0;
      acnt_n  = '0;
      bcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          page_n = 2'd0;
          cnt_n  = '0;
          hit    = find_valid(2'd0, stat_valid);
          if (hit[2]) begin
            state_n = SHOW;
            page_n  = hit[1:0];
          end
        end
        SHOW: begin
          if (!stat_valid[page]) begin
            cnt_n = '0;
            hit   = find_valid(page + 2'd1, stat_valid);
            if (hit[2]) begin
              page_n = hit[1:0];
            end else begin
              state_n = IDLE;
              page_n  = 2'd0;
            end
          end else if (!hold) begin
            if (cnt == PAGE_LAST) begin
              cnt_n  = '0;
              hit    = find_valid(page + 2'd1, stat_valid);
              page_n = hit[1:0];
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        ALERT: begin
          if (acnt == ALERT_LAST) begin
            acnt_n = '0;
            bcnt_n = '0;
            cnt_n  = '0;
            hit    = find_valid(saved, stat_valid);
            if (hit[2]) begin
              state_n = SHOW;
              page_n  = hit[1:0];
            end else begin
              state_n = IDLE;
              page_n  = 2'd0;
            end
          end else begin
            acnt_n = acnt + 1'b1;
            if (bcnt == BLINK_LAST) begin
              bcnt_n  = '0;
              blank_n = ~blank;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          page_n  = 2'd0;
        end
      endcase

      if (state_n == SHOW) begin
        nib_n   = pick_stat(page_n);
        blank_n = lz_blank(pick_stat(page_n));
      end else if (state_n == IDLE) begin
        nib_n   = 16'h0000;
        blank_n = 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_hex_page_scheduler.sv
// Directed testbench for hex_page_scheduler with short page/alert/blink periods.
module tb_hex_page_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  stat_valid = 3'b000;
  logic [15:0] stat0 = 16'h0000;
  logic [15:0] stat1 = 16'h0000;
  logic [15:0] stat2 = 16'h0000;
  logic        alert_req = 1'b0;
  logic [15:0] alert_val = 16'h0000;
  logic        hold = 1'b0;
  logic        alert_ack;
  logic [15:0] nib;
  logic [3:0]  blank;
  logic [1:0]  page;

  int errors = 0;
  int checks = 0;

  hex_page_scheduler #(
    .TICKS_PER_PAGE(4),
    .ALERT_TICKS(8),
    .BLINK_TICKS(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stat_valid(stat_valid),
    .stat0(stat0),
    .stat1(stat1),
    .stat2(stat2),
    .alert_req(alert_req),
    .alert_val(alert_val),
    .hold(hold),
    .alert_ack(alert_ack),
    .nib(nib),
    .blank(blank),
    .page(page)
  );

  // Free-running 100 MHz clock
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Bring the DUT to a clean idle state
  task automatic do_reset();
    reset = 1'b1;
    alert_req = 1'b0;
    hold = 1'b0;
    stat_valid = 3'b000;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Reset values and idle behaviour with no sources present
  task automatic test_reset();
    reset = 1'b1;
    alert_req = 1'b0;
    stat_valid = 3'b111;
    step();
    step();
    checks++;
    if (page !== 2'd0 || blank !== 4'hF || nib !== 16'h0000 || alert_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got page=%0d blank=%h nib=%h ack=%b exp page=0 blank=f nib=0000 ack=0", page, blank, nib, alert_ack);
    end
    stat_valid = 3'b000;
    reset = 1'b0;
    step();
    checks++;
    if (blank !== 4'hF || nib !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL idle_dark got blank=%h nib=%h exp blank=f nib=0000", blank, nib);
    end
  endtask

  // Round-robin over sources 0 and 2 with leading-zero blanking
  task automatic test_rotation();
    logic [1:0]  ep;
    logic [15:0] en;
    logic [3:0]  eb;
    do_reset();
    stat0 = 16'h0042;
    stat1 = 16'hFFFF;
    stat2 = 16'h1234;
    stat_valid = 3'b101;
    for (int i = 0; i < 12; i++) begin
      step();
      ep = (((i / 4) % 2) == 1) ? 2'd2 : 2'd0;
      en = (ep == 2'd2) ? 16'h1234 : 16'h0042;
      eb = (ep == 2'd2) ? 4'b0000 : 4'b1100;
      checks++;
      if (page !== ep || nib !== en || blank !== eb) begin
        errors++;
        $display("[TB] FAIL rotation i=%0d got page=%0d nib=%h blank=%b exp page=%0d nib=%h blank=%b", i, page, nib, blank, ep, en, eb);
      end
    end
  endtask

  // Hold freezes rotation while nib keeps tracking the live source
  task automatic test_hold();
    do_reset();
    stat0 = 16'h0042;
    stat2 = 16'h1234;
    stat_valid = 3'b101;
    step();
    step();
    hold = 1'b1;
    stat0 = 16'h0007;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (page !== 2'd0) begin
        errors++;
        $display("[TB] FAIL hold_page i=%0d got=%0d exp=0", i, page);
      end
    end
    checks++;
    if (nib !== 16'h0007 || blank !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL hold_live got nib=%h blank=%b exp nib=0007 blank=1110", nib, blank);
    end
    hold = 1'b0;
    step();
    step();
    checks++;
    if (page !== 2'd0) begin
      errors++;
      $display("[TB] FAIL hold_remaining got=%0d exp=0", page);
    end
    step();
    checks++;
    if (page !== 2'd2) begin
      errors++;
      $display("[TB] FAIL hold_wrap got=%0d exp=2", page);
    end
  endtask

  // Alert taken from page 2: ack pulse, blink pattern, return to page 2
  task automatic test_alert();
    logic [3:0] eb;
    alert_val = 16'hBEEF;
    alert_req = 1'b1;
    step();
    checks++;
    if (alert_ack !== 1'b1 || page !== 2'd3 || nib !== 16'hBEEF || blank !== 4'h0) begin
      errors++;
      $display("[TB] FAIL alert_entry got ack=%b page=%0d nib=%h blank=%h exp ack=1 page=3 nib=beef blank=0", alert_ack, page, nib, blank);
    end
    alert_req = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      eb = (((k / 2) % 2) == 1) ? 4'hF : 4'h0;
      checks++;
      if (blank !== eb || page !== 2'd3 || alert_ack !== 1'b0 || nib !== 16'hBEEF) begin
        errors++;
        $display("[TB] FAIL alert_blink k=%0d got blank=%h page=%0d ack=%b nib=%h exp blank=%h page=3 ack=0 nib=beef", k, blank, page, alert_ack, nib, eb);
      end
    end
    step();
    checks++;
    if (page !== 2'd2 || nib !== 16'h1234 || blank !== 4'h0 || alert_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alert_exit got page=%0d nib=%h blank=%h ack=%b exp page=2 nib=1234 blank=0 ack=0", page, nib, blank, alert_ack);
    end
  endtask

  // Alert request held across the whole alert: ignored inside, re-accepted after exit
  task automatic test_back_to_back();
    alert_val = 16'h0A0B;
    alert_req = 1'b1;
    step();
    checks++;
    if (alert_ack !== 1'b1 || page !== 2'd3) begin
      errors++;
      $display("[TB] FAIL b2b_first got ack=%b page=%0d exp ack=1 page=3", alert_ack, page);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      checks++;
      if (alert_ack !== 1'b0 || page !== 2'd3) begin
        errors++;
        $display("[TB] FAIL b2b_ignore k=%0d got ack=%b page=%0d exp ack=0 page=3", k, alert_ack, page);
      end
    end
    alert_val = 16'hC0DE;
    step();
    checks++;
    if (page !== 2'd2 || alert_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_exit got page=%0d ack=%b exp page=2 ack=0", page, alert_ack);
    end
    step();
    checks++;
    if (alert_ack !== 1'b1 || page !== 2'd3 || nib !== 16'hC0DE) begin
      errors++;
      $display("[TB] FAIL b2b_reaccept got ack=%b page=%0d nib=%h exp ack=1 page=3 nib=c0de", alert_ack, page, nib);
    end
    alert_req = 1'b0;
  endtask

  // Alert landing on the wrap cycle wins and returns to the pre-wrap page
  task automatic test_alert_at_wrap();
    do_reset();
    stat0 = 16'h0042;
    stat2 = 16'h1234;
    stat_valid = 3'b101;
    for (int i = 0; i < 4; i++) step();
    alert_val = 16'h1111;
    alert_req = 1'b1;
    step();
    checks++;
    if (page !== 2'd3 || alert_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_alert got page=%0d ack=%b exp page=3 ack=1", page, alert_ack);
    end
    alert_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (page !== 2'd3) begin
      errors++;
      $display("[TB] FAIL wrap_alert_len got page=%0d exp=3", page);
    end
    step();
    checks++;
    if (page !== 2'd0 || nib !== 16'h0042) begin
      errors++;
      $display("[TB] FAIL wrap_return got page=%0d nib=%h exp page=0 nib=0042", page, nib);
    end
  endtask

  // Saved page lost during the alert: exit moves to the next valid source
  task automatic test_alert_fallback();
    do_reset();
    stat1 = 16'h00F0;
    stat_valid = 3'b011;
    step();
    alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    stat_valid = 3'b010;
    for (int i = 0; i < 7; i++) step();
    step();
    checks++;
    if (page !== 2'd1 || nib !== 16'h00F0 || blank !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL fallback got page=%0d nib=%h blank=%b exp page=1 nib=00f0 blank=1100", page, nib, blank);
    end
  endtask

  // Sources disappearing mid-page, falling to idle, and a lone source staying put
  task automatic test_drop();
    do_reset();
    stat0 = 16'h0042;
    stat2 = 16'h1234;
    stat_valid = 3'b101;
    step();
    hold = 1'b1;
    stat_valid = 3'b100;
    step();
    checks++;
    if (page !== 2'd2 || nib !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL drop_advance got page=%0d nib=%h exp page=2 nib=1234", page, nib);
    end
    stat_valid = 3'b000;
    step();
    checks++;
    if (blank !== 4'hF || nib !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL drop_idle got blank=%h nib=%h exp blank=f nib=0000", blank, nib);
    end
    hold = 1'b0;
    stat1 = 16'h0000;
    stat_valid = 3'b010;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (page !== 2'd1 || blank !== 4'b1110 || nib !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL single_source i=%0d got page=%0d blank=%b nib=%h exp page=1 blank=1110 nib=0000", i, page, blank, nib);
      end
    end
  endtask

  // Reset in the middle of an alert, with the request still pending afterwards
  task automatic test_reset_in_alert();
    do_reset();
    stat0 = 16'h0042;
    stat_valid = 3'b001;
    step();
    alert_val = 16'hBEEF;
    alert_req = 1'b1;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (blank !== 4'hF || page !== 2'd0 || alert_ack !== 1'b0 || nib !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_alert got blank=%h page=%0d ack=%b nib=%h exp blank=f page=0 ack=0 nib=0000", blank, page, alert_ack, nib);
    end
    reset = 1'b0;
    step();
    checks++;
    if (alert_ack !== 1'b1 || page !== 2'd3) begin
      errors++;
      $display("[TB] FAIL reset_reaccept got ack=%b page=%0d exp ack=1 page=3", alert_ack, page);
    end
    alert_req = 1'b0;
  endtask

  // Run all scenarios in order
  initial begin
    test_reset();
    test_rotation();
    test_hold();
    test_alert();
    test_back_to_back();
    test_alert_at_wrap();
    test_alert_fallback();
    test_drop();
    test_reset_in_alert();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
